// File: rtl/vga_fb_responder.sv
// vga_fb_responder
//   Memory-side responder for the VGA data controller's framebuffer reads.
//   Holds a DEPTH x 32-bit word array, answers each accepted VGA read with
//   byte-masked data, a one-cycle data_en strobe and the echoed byte select
//   READ_LATENCY edges after the accept. A CPU write port shares the array;
//   VGA reads always win over writes.
//
//   Optional feature macro: FB_ADDR_CHECK_EN
//     defined   : word index >= DEPTH is out of range; reads return 0,
//                 writes are dropped, addr_err pulses for one cycle.
//     undefined : word index wraps modulo DEPTH, addr_err tied 0.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   read              VGA read request, held until accepted
//   SRAM_address      VGA byte address (word index = [31:2])
//   byte_select_out   VGA byte lanes requested
//   data_from_SRAM    masked read data, valid with data_en, held otherwise
//   data_en           one-cycle response strobe
//   byte_select_in    echoed byte select, valid with data_en
//   SRAM_busy         high while a read is outstanding
//   wr_en             CPU write request, held while wr_busy
//   wr_addr           CPU byte address (word index = [31:2])
//   wr_data           CPU write data
//   wr_byte_sel       CPU byte-lane write enables
//   wr_busy           combinational: write not taken this cycle
//   addr_err          one-cycle out-of-range pulse
module vga_fb_responder #(
    parameter int unsigned DEPTH        = 384,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [31:0] SRAM_address,
    input  logic [3:0]  byte_select_out,
    output logic [31:0] data_from_SRAM,
    output logic        data_en,
    output logic [3:0]  byte_select_in,
    output logic        SRAM_busy,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_byte_sel,
    output logic        wr_busy,
    output logic        addr_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] rd_idx, rd_idx_in, wr_idx_in;
    logic [3:0]    rd_sel;
    logic [31:0]   rd_word_addr, wr_word_addr;
    logic [31:0]   rd_masked;
    logic          accept;
    logic          wr_commit;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{SRAM_address[1:0], wr_addr[1:0]};

    assign rd_word_addr = {2'b00, SRAM_address[31:2]};
    assign wr_word_addr = {2'b00, wr_addr[31:2]};

`ifdef FB_ADDR_CHECK_EN
    logic rd_oor_in, wr_oor_in, rd_oor;

    assign rd_oor_in = (rd_word_addr >= DEPTH);
    assign wr_oor_in = (wr_word_addr >= DEPTH);
    assign rd_idx_in = rd_oor_in ? '0 : rd_word_addr[AW-1:0];
    assign wr_idx_in = wr_word_addr[AW-1:0];
`else
    assign rd_idx_in = AW'(rd_word_addr % DEPTH);
    assign wr_idx_in = AW'(wr_word_addr % DEPTH);
`endif

    // A read is taken in IDLE, or in RESPOND so a held request streams
    // back to back with one response every READ_LATENCY cycles.
    assign accept    = read && (state != WAIT);
    assign SRAM_busy = (state != IDLE);
    assign wr_busy   = (state == WAIT) || (read && (state != WAIT));

`ifdef FB_ADDR_CHECK_EN
    assign wr_commit = wr_en && !wr_busy && !rst && !wr_oor_in;
`else
    assign wr_commit = wr_en && !wr_busy && !rst;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE, RESPOND: begin
                if (read) begin
                    cnt_next   = 4'(READ_LATENCY - 1);
                    state_next = (READ_LATENCY == 1) ? RESPOND : WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt_next == '0) begin
                    state_next = RESPOND;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        rd_masked = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (rd_sel[b]) begin
                rd_masked[8*b +: 8] = mem[rd_idx][8*b +: 8];
            end
        end
`ifdef FB_ADDR_CHECK_EN
        if (rd_oor) begin
            rd_masked = '0;
        end
`endif
    end

    // The response is registered on the edge that leaves RESPOND, which is
    // also the edge a held read is re-accepted; this gives latency L and
    // throughput one per L cycles together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            data_from_SRAM <= '0;
            data_en        <= 1'b0;
            byte_select_in <= '0;
            rd_idx         <= '0;
            rd_sel         <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            data_en <= (state == RESPOND);
            if (state == RESPOND) begin
                data_from_SRAM <= rd_masked;
                byte_select_in <= rd_sel;
            end
            if (accept) begin
                rd_idx <= rd_idx_in;
                rd_sel <= byte_select_out;
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_byte_sel[b]) begin
                    mem[wr_idx_in][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

`ifdef FB_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_oor   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (accept) begin
                rd_oor <= rd_oor_in;
            end
            addr_err <= ((state == RESPOND) && rd_oor)
                      || (wr_en && !wr_busy && wr_oor_in);
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_responder.sv
// tb_vga_fb_responder
//   Directed self-checking bench for vga_fb_responder (DEPTH=384,
//   READ_LATENCY=2). Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point. Honours FB_ADDR_CHECK_EN.
module tb_vga_fb_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [31:0] SRAM_address;
    logic [3:0]  byte_select_out;
    logic [31:0] data_from_SRAM;
    logic        data_en;
    logic [3:0]  byte_select_in;
    logic        SRAM_busy;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_sel;
    logic        wr_busy;
    logic        addr_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd_data;
    logic [3:0]  rd_bsel;
    logic        rd_err;
    int          rd_lat;
    logic        exp_en;
    logic [31:0] b2b [4];

    vga_fb_responder #(
        .DEPTH        (384),
        .READ_LATENCY (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .read            (read),
        .SRAM_address    (SRAM_address),
        .byte_select_out (byte_select_out),
        .data_from_SRAM  (data_from_SRAM),
        .data_en         (data_en),
        .byte_select_in  (byte_select_in),
        .SRAM_busy       (SRAM_busy),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_byte_sel     (wr_byte_sel),
        .wr_busy         (wr_busy),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read from IDLE and wait (bounded) for data_en.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] sel,
                           output logic [31:0] data, output logic [3:0] bsel,
                           output logic err, output int lat);
        read            = 1'b1;
        SRAM_address    = addr;
        byte_select_out = sel;
        tick();
        read = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (data_en) begin
                lat = i;
                break;
            end
        end
        data = data_from_SRAM;
        bsel = byte_select_in;
        err  = addr_err;
    endtask

    // Present a write and hold it until it is taken (bounded).
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel);
        wr_en       = 1'b1;
        wr_addr     = addr;
        wr_data     = data;
        wr_byte_sel = sel;
        #1;
        for (int i = 0; i < 16 && wr_busy; i++) begin
            tick();
        end
        check("wr_stall", {31'd0, wr_busy}, 32'd0);
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        b2b[0] = 32'hB05AC310;
        b2b[1] = 32'hB15AC311;
        b2b[2] = 32'hB25AC312;
        b2b[3] = 32'hB35AC313;

        rst             = 1'b1;
        read            = 1'b1;
        SRAM_address    = 32'h0;
        byte_select_out = 4'hF;
        wr_en           = 1'b0;
        wr_addr         = '0;
        wr_data         = '0;
        wr_byte_sel     = '0;

        // Reset held with read asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_data_en", {31'd0, data_en}, 32'd0);
            check("rst_busy", {31'd0, SRAM_busy}, 32'd0);
        end
        check("rst_data", data_from_SRAM, 32'd0);
        check("rst_bsel", {28'd0, byte_select_in}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);

        // First accept right after reset release; data_en 2 edges later.
        rst = 1'b0;
        tick();
        read = 1'b0;
        check("acc_busy", {31'd0, SRAM_busy}, 32'd1);
        check("acc_en0", {31'd0, data_en}, 32'd0);
        tick();
        check("acc_en1", {31'd0, data_en}, 32'd0);
        check("acc_busy1", {31'd0, SRAM_busy}, 32'd1);
        tick();
        check("acc_en2", {31'd0, data_en}, 32'd1);
        check("acc_busy2", {31'd0, SRAM_busy}, 32'd0);
        tick();
        check("acc_en3", {31'd0, data_en}, 32'd0);

        // Full write and read back.
        do_write(32'h14, 32'h02468ACF, 4'hF);
        do_read(32'h14, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
        check("wr_rd_data", rd_data, 32'h02468ACF);
        check("wr_rd_bsel", {28'd0, rd_bsel}, 32'hF);
        check("wr_rd_lat", rd_lat, 32'd2);

        // Masked read: lanes 0 and 2 only.
        do_read(32'h14, 4'h5, rd_data, rd_bsel, rd_err, rd_lat);
        check("mask_data", rd_data, 32'h004600CF);
        check("mask_bsel", {28'd0, rd_bsel}, 32'h5);
        tick();
        check("hold_data", data_from_SRAM, 32'h004600CF);

        // Partial lane write.
        do_write(32'h20, 32'h3FFFFFFC, 4'hF);
        do_write(32'h20, 32'hAAAAAAAA, 4'h2);
        do_read(32'h20, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
        check("part_data", rd_data, 32'h3FFFAAFC);

        // Conflict in IDLE, read dropped after accept.
        do_write(32'h30, 32'h11111111, 4'hF);
        read = 1'b1; SRAM_address = 32'h30; byte_select_out = 4'hF;
        wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'h22222222; wr_byte_sel = 4'hF;
        #1;
        check("conf_busy_idle", {31'd0, wr_busy}, 32'd1);
        tick();
        read = 1'b0;
        #1;
        check("conf_busy_wait", {31'd0, wr_busy}, 32'd1);
        tick();
        check("conf_busy_resp", {31'd0, wr_busy}, 32'd0);
        check("conf_no_en", {31'd0, data_en}, 32'd0);
        tick();
        wr_en = 1'b0;
        check("conf_en", {31'd0, data_en}, 32'd1);
        check("conf_old", data_from_SRAM, 32'h11111111);
        do_read(32'h30, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
        check("conf_new", rd_data, 32'h22222222);

        // Conflict with read held across a response: write waits for the next one.
        read = 1'b1; SRAM_address = 32'h30; byte_select_out = 4'hF;
        wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'h33333333; wr_byte_sel = 4'hF;
        tick();
        tick();
        check("held_busy_resp", {31'd0, wr_busy}, 32'd1);
        tick();
        check("held_en1", {31'd0, data_en}, 32'd1);
        check("held_d1", data_from_SRAM, 32'h22222222);
        read = 1'b0;
        #1;
        check("held_busy_wait", {31'd0, wr_busy}, 32'd1);
        tick();
        tick();
        wr_en = 1'b0;
        check("held_en2", {31'd0, data_en}, 32'd1);
        check("held_d2", data_from_SRAM, 32'h22222222);
        do_read(32'h30, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
        check("held_new", rd_data, 32'h33333333);

        // Back-to-back reads of words 0..3 with read held.
        for (int i = 0; i < 4; i++) begin
            do_write(32'(i * 4), b2b[i], 4'hF);
        end
        read = 1'b1; SRAM_address = 32'h0; byte_select_out = 4'hF;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1 || t == 3 || t == 5) SRAM_address = 32'(((t + 1) / 2) * 4);
            if (t == 7) read = 1'b0;
            exp_en = (t == 3 || t == 5 || t == 7 || t == 9);
            check("b2b_en", {31'd0, data_en}, {31'd0, exp_en});
            if (exp_en) check("b2b_data", data_from_SRAM, b2b[(t - 3) / 2]);
        end

        // Out-of-range read at word index DEPTH.
        do_read(32'd1536, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
`ifdef FB_ADDR_CHECK_EN
        check("oor_rd_data", rd_data, 32'd0);
        check("oor_rd_err", {31'd0, rd_err}, 32'd1);
        tick();
        check("oor_rd_err_clr", {31'd0, addr_err}, 32'd0);
        do_write(32'd1536, 32'hFFFFFFFF, 4'hF);
        check("oor_wr_err", {31'd0, addr_err}, 32'd1);
        tick();
        check("oor_wr_err_clr", {31'd0, addr_err}, 32'd0);
        do_read(32'h0, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
        check("oor_wr_dropped", rd_data, b2b[0]);
`else
        check("wrap_rd_data", rd_data, b2b[0]);
        check("wrap_rd_err", {31'd0, rd_err}, 32'd0);
`endif

        // Write presented during reset is dropped.
        do_write(32'h40, 32'h5555AAAA, 4'hF);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h12345678; wr_byte_sel = 4'hF;
        tick();
        rst = 1'b0;
        wr_en = 1'b0;
        do_read(32'h40, 4'hF, rd_data, rd_bsel, rd_err, rd_lat);
        check("rst_wr_drop", rd_data, 32'h5555AAAA);

        // Reset in WAIT discards the pending read.
        read = 1'b1; SRAM_address = 32'h14; byte_select_out = 4'hF;
        tick();
        read = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, SRAM_busy}, 32'd0);
        check("midrst_en", {31'd0, data_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_en", {31'd0, data_en}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
